// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-RAM loader.
// The default fill word is all-ones and covers word widths up to 64 bits.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FILL = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam logic [63:0] DEF_END_WORD = '1;

endpackage

// File: rtl/imem_loader.sv
// Streams a program into instruction RAM, pads the remainder with END_WORD and releases the CPU.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds an XOR checksum of accepted program words.
//
// state | meaning
// IDLE  | after reset, CPU held, waiting for START
// LOAD  | accepting program words from the stream
// FILL  | writing END_WORD up to the last RAM address
// FIN   | image complete, CPU released, waiting for START
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned           WORD_W   = 32,
  parameter int unsigned           DEPTH    = 512,
  parameter logic [WORD_W-1:0]     END_WORD = WORD_W'(DEF_END_WORD)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       START,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [WORD_W-1:0]          IN_DATA,
  input  logic                       IN_LAST,
  output logic                       WE,
  output logic [$clog2(DEPTH)-1:0]   WADDR,
  output logic [WORD_W-1:0]          WDATA,
  output logic                       CPU_HOLD,
  output logic                       DONE,
  output logic                       OVERFLOW,
  output logic [$clog2(DEPTH):0]     LOAD_COUNT
`ifdef IMEM_LOADER_CHECKSUM_EN
  , output logic [WORD_W-1:0]        CHECKSUM
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_MAX   = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          start_ok;
  logic          xfer;

  assign start_ok = START && ((state_q == ST_IDLE) || (state_q == ST_FIN));
  assign xfer     = (state_q == ST_LOAD) && IN_VALID;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    IN_READY = 1'b0;
    WE       = 1'b0;
    WDATA    = '0;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (start_ok) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          WE    = 1'b1;
          WDATA = IN_DATA;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          // The last address is held rather than incremented so it can never wrap.
          if (addr_q == LAST_ADDR) begin
            state_d = ST_FIN;
            ovf_d   = !IN_LAST;
          end else begin
            addr_d = addr_q + 1'b1;
            if (IN_LAST) state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        WE    = 1'b1;
        WDATA = END_WORD;
        if (addr_q == LAST_ADDR) state_d = ST_FIN;
        else                     addr_d  = addr_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign WADDR      = addr_q;
  assign DONE       = (state_q == ST_FIN);
  assign CPU_HOLD   = (state_q != ST_FIN);
  assign OVERFLOW   = ovf_q;
  assign LOAD_COUNT = cnt_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_ok)  csum_d = '0;
    else if (xfer) csum_d = csum_q ^ IN_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign CHECKSUM = csum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader at DEPTH=8: fill, full image, overflow, gaps, reset and restart.
module tb_imem_loader;

  localparam int WW = 32;
  localparam int DP = 8;

  logic          CLK = 1'b0;
  logic          RESET, START, IN_VALID, IN_LAST;
  logic [WW-1:0] IN_DATA;
  logic          IN_READY, WE, CPU_HOLD, DONE, OVERFLOW;
  logic [2:0]    WADDR;
  logic [WW-1:0] WDATA;
  logic [3:0]    LOAD_COUNT;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WW-1:0] CHECKSUM;
`endif

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;
  logic [WW-1:0] ram [DP];

  imem_loader #(.WORD_W(WW), .DEPTH(DP)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_LAST(IN_LAST),
    .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .CPU_HOLD(CPU_HOLD),
    .DONE(DONE), .OVERFLOW(OVERFLOW), .LOAD_COUNT(LOAD_COUNT)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .CHECKSUM(CHECKSUM)
`endif
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (WE === 1'b1) begin
      ram[WADDR] = WDATA;
      wr_count++;
    end
  end

  task automatic clear_ram();
    for (int i = 0; i < DP; i++) ram[i] = 32'hDEAD_BEEF;
    wr_count = 0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RESET = 1'b1; START = 1'b0; IN_VALID = 1'b0; IN_LAST = 1'b0; IN_DATA = '0;
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic send_word(input logic [WW-1:0] d, input logic last, input logic [2:0] exp_addr);
    IN_VALID = 1'b1; IN_DATA = d; IN_LAST = last;
    @(negedge CLK);
    checks++;
    if (WE !== 1'b1 || IN_READY !== 1'b1 || WADDR !== exp_addr || WDATA !== d) begin
      failures++;
      $display("FAIL send_word: we=%b rdy=%b addr=%0d data=%h, required we=1 rdy=1 addr=%0d data=%h",
               WE, IN_READY, WADDR, WDATA, exp_addr, d);
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0; IN_LAST = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (DONE !== 1'b1 && k < 40) begin
      @(posedge CLK); #1;
      k++;
    end
    if (DONE !== 1'b1) begin
      checks++; failures++;
      $display("FAIL wait_done: DONE=%b after %0d cycles, required 1", DONE, k);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    checks++;
    if ({IN_READY, WE, CPU_HOLD, DONE, OVERFLOW} !== 5'b00100) begin
      failures++;
      $display("FAIL reset_flags: rdy/we/hold/done/ovf=%b, required 00100",
               {IN_READY, WE, CPU_HOLD, DONE, OVERFLOW});
    end
    checks++;
    if (WADDR !== 3'd0 || WDATA !== 32'd0 || LOAD_COUNT !== 4'd0) begin
      failures++;
      $display("FAIL reset_values: waddr=%0d wdata=%h cnt=%0d, required 0 0 0", WADDR, WDATA, LOAD_COUNT);
    end
  endtask

  task automatic test_fill_three();
    logic [WW-1:0] exp [DP];
    int k;
    exp = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C, '1, '1, '1, '1, '1};
    clear_ram();
    do_reset();
    pulse_start();
    send_word(exp[0], 1'b0, 3'd0);
    send_word(exp[1], 1'b0, 3'd1);
    send_word(exp[2], 1'b1, 3'd2);
    checks++;
    if (IN_READY !== 1'b0 || WE !== 1'b1 || WDATA !== '1) begin
      failures++;
      $display("FAIL fill_first: rdy=%b we=%b wdata=%h, required 0 1 ffffffff", IN_READY, WE, WDATA);
    end
    wait_done(k);
    checks++;
    if (k !== 5) begin
      failures++;
      $display("FAIL fill_latency: %0d cycles, required 5", k);
    end
    for (int i = 0; i < DP; i++) begin
      checks++;
      if (ram[i] !== exp[i]) begin
        failures++;
        $display("FAIL fill_ram[%0d]: %h, required %h", i, ram[i], exp[i]);
      end
    end
    checks++;
    if (LOAD_COUNT !== 4'd3 || OVERFLOW !== 1'b0 || CPU_HOLD !== 1'b0 || wr_count !== 8) begin
      failures++;
      $display("FAIL fill_status: cnt=%0d ovf=%b hold=%b writes=%0d, required 3 0 0 8",
               LOAD_COUNT, OVERFLOW, CPU_HOLD, wr_count);
    end
    @(negedge CLK);
    checks++;
    if (WE !== 1'b0 || IN_READY !== 1'b0 || DONE !== 1'b1) begin
      failures++;
      $display("FAIL fin_hold: we=%b rdy=%b done=%b, required 0 0 1", WE, IN_READY, DONE);
    end
  endtask

  task automatic test_full_eight();
    clear_ram();
    pulse_start();
    for (int i = 0; i < DP; i++) send_word(32'h100 + i, (i == DP - 1), 3'(i));
    checks++;
    if (DONE !== 1'b1 || OVERFLOW !== 1'b0 || LOAD_COUNT !== 4'd8 || wr_count !== 8) begin
      failures++;
      $display("FAIL full_eight: done=%b ovf=%b cnt=%0d writes=%0d, required 1 0 8 8",
               DONE, OVERFLOW, LOAD_COUNT, wr_count);
    end
    checks++;
    if (ram[7] !== 32'h107 || ram[0] !== 32'h100) begin
      failures++;
      $display("FAIL full_ram: ram0=%h ram7=%h, required 00000100 00000107", ram[0], ram[7]);
    end
  endtask

  task automatic test_overflow();
    clear_ram();
    pulse_start();
    for (int i = 0; i < DP; i++) send_word(32'h200 + i, 1'b0, 3'(i));
    IN_VALID = 1'b1; IN_DATA = 32'h208; IN_LAST = 1'b0;
    @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b0 || WE !== 1'b0) begin
      failures++;
      $display("FAIL ovf_ninth: rdy=%b we=%b, required 0 0", IN_READY, WE);
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    checks++;
    if (OVERFLOW !== 1'b1 || LOAD_COUNT !== 4'd8 || wr_count !== 8 || ram[7] !== 32'h207) begin
      failures++;
      $display("FAIL ovf_status: ovf=%b cnt=%0d writes=%0d ram7=%h, required 1 8 8 00000207",
               OVERFLOW, LOAD_COUNT, wr_count, ram[7]);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] pat;
    int sent, k;
    pat = 8'b1001_0110;
    clear_ram();
    pulse_start();
    checks++;
    if (OVERFLOW !== 1'b0 || LOAD_COUNT !== 4'd0) begin
      failures++;
      $display("FAIL start_clear: ovf=%b cnt=%0d, required 0 0", OVERFLOW, LOAD_COUNT);
    end
    sent = 0;
    for (int c = 0; c < 8; c++) begin
      IN_VALID = pat[c]; IN_DATA = 32'h300 + sent; IN_LAST = (sent == 3);
      @(negedge CLK);
      checks++;
      if (WE !== pat[c] || (pat[c] && WADDR !== 3'(sent))) begin
        failures++;
        $display("FAIL gap_cycle%0d: we=%b addr=%0d, required we=%b addr=%0d", c, WE, WADDR, pat[c], sent);
      end
      @(posedge CLK); #1;
      if (pat[c]) sent++;
    end
    IN_VALID = 1'b0; IN_LAST = 1'b0;
    wait_done(k);
    checks++;
    if (LOAD_COUNT !== 4'd4 || ram[3] !== 32'h303 || ram[4] !== '1 || wr_count !== 8) begin
      failures++;
      $display("FAIL gap_result: cnt=%0d ram3=%h ram4=%h writes=%0d, required 4 00000303 ffffffff 8",
               LOAD_COUNT, ram[3], ram[4], wr_count);
    end
  endtask

  task automatic test_reset_in_fill();
    int k;
    clear_ram();
    pulse_start();
    send_word(32'h400, 1'b0, 3'd0);
    send_word(32'h401, 1'b1, 3'd1);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    checks++;
    if (CPU_HOLD !== 1'b1 || DONE !== 1'b0 || IN_READY !== 1'b0 || WE !== 1'b0 || LOAD_COUNT !== 4'd0) begin
      failures++;
      $display("FAIL reset_fill: hold=%b done=%b rdy=%b we=%b cnt=%0d, required 1 0 0 0 0",
               CPU_HOLD, DONE, IN_READY, WE, LOAD_COUNT);
    end
    repeat (10) @(posedge CLK);
    #1;
    checks++;
    if (DONE !== 1'b0 || WE !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: done=%b we=%b, required 0 0", DONE, WE);
    end
    clear_ram();
    pulse_start();
    send_word(32'h500, 1'b0, 3'd0);
    send_word(32'h501, 1'b0, 3'd1);
    send_word(32'h502, 1'b1, 3'd2);
    wait_done(k);
    checks++;
    if (k !== 5 || LOAD_COUNT !== 4'd3 || ram[2] !== 32'h502 || ram[7] !== '1) begin
      failures++;
      $display("FAIL reload: lat=%0d cnt=%0d ram2=%h ram7=%h, required 5 3 00000502 ffffffff",
               k, LOAD_COUNT, ram[2], ram[7]);
    end
  endtask

  task automatic test_start_handling();
    int k;
    do_reset();
    pulse_start();
    send_word(32'h600, 1'b0, 3'd0);
    pulse_start();
    send_word(32'h601, 1'b1, 3'd1);
    wait_done(k);
    checks++;
    if (LOAD_COUNT !== 4'd2 || ram[1] !== 32'h601) begin
      failures++;
      $display("FAIL start_in_load: cnt=%0d ram1=%h, required 2 00000601", LOAD_COUNT, ram[1]);
    end
    pulse_start();
    checks++;
    if (DONE !== 1'b0 || LOAD_COUNT !== 4'd0 || IN_READY !== 1'b1 || CPU_HOLD !== 1'b1) begin
      failures++;
      $display("FAIL start_in_fin: done=%b cnt=%0d rdy=%b hold=%b, required 0 0 1 1",
               DONE, LOAD_COUNT, IN_READY, CPU_HOLD);
    end
    send_word(32'd1, 1'b0, 3'd0);
    send_word(32'd2, 1'b0, 3'd1);
    send_word(32'd4, 1'b1, 3'd2);
    wait_done(k);
    checks++;
    if (LOAD_COUNT !== 4'd3 || k !== 5) begin
      failures++;
      $display("FAIL restart_load: cnt=%0d lat=%0d, required 3 5", LOAD_COUNT, k);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    checks++;
    if (CHECKSUM !== 32'd7) begin
      failures++;
      $display("FAIL checksum: %h, required 00000007", CHECKSUM);
    end
`endif
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; IN_VALID = 1'b0; IN_LAST = 1'b0; IN_DATA = '0;
    test_reset();
    test_fill_three();
    test_full_eight();
    test_overflow();
    test_gaps();
    test_reset_in_fill();
    test_start_handling();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter WORD_W, default 32: instruction word width in bits.
REQ-002 Parameter DEPTH, default 512: instruction RAM depth in words, power of two, at least 2.
REQ-003 Parameter END_WORD, default all-ones of WORD_W: fill value written after the last program word.
REQ-004 Port CLK, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port RESET, input, 1: synchronous, active-high reset.
REQ-006 Port START, input, 1: one-cycle pulse that begins a load.
REQ-007 Port IN_VALID, input, 1: IN_DATA and IN_LAST are valid.
REQ-008 Port IN_READY, output, 1: loader accepts a word this cycle.
REQ-009 Port IN_DATA, input, WORD_W: program word.
REQ-010 Port IN_LAST, input, 1: the current word is the final program word.
REQ-011 Port WE, output, 1: RAM write enable.
REQ-012 Port WADDR, output, clog2(DEPTH): RAM write address.
REQ-013 Port WDATA, output, WORD_W: RAM write data.
REQ-014 Port CPU_HOLD, output, 1: keeps the CPU stalled while high.
REQ-015 Port DONE, output, 1: the RAM image is complete.
REQ-016 Port OVERFLOW, output, 1: the stream exceeded DEPTH words.
REQ-017 Port LOAD_COUNT, output, clog2(DEPTH)+1: number of program words accepted.

Function
REQ-018 FSM states are IDLE, LOAD, FILL and FIN.
REQ-019 START in IDLE or FIN shall enter LOAD and clear the address, LOAD_COUNT, DONE and OVERFLOW; START in LOAD or FILL is ignored.
REQ-020 In LOAD, IN_READY=1; a word transfers when IN_VALID and IN_READY are both high.
REQ-021 Each transfer shall, combinationally in the same cycle, drive WE=1, WADDR=address and WDATA=IN_DATA; the address and LOAD_COUNT then increment.
REQ-022 A transfer with IN_LAST=1 at address below DEPTH-1 shall go to FILL.
REQ-023 A transfer at address DEPTH-1 shall go to FIN.
- If IN_LAST=0 on that transfer, OVERFLOW shall be set and stay set until the next START or RESET.
REQ-024 In FILL, the loader shall write END_WORD to one address per cycle (WE=1, IN_READY=0) through address DEPTH-1, then go to FIN.
REQ-025 In FIN, DONE=1, CPU_HOLD=0 and IN_READY=0; the state holds until START.
REQ-026 CPU_HOLD=1 in IDLE, LOAD and FILL.
REQ-027 WE=0 in IDLE and FIN, and in LOAD cycles without a transfer.
REQ-028 Load latency: N program words with N < DEPTH give DONE exactly DEPTH-N cycles after the final transfer.
REQ-029 Address and LOAD_COUNT arithmetic shall never wrap; no write beyond DEPTH-1 ever occurs.
REQ-030 LOAD_COUNT saturates at DEPTH.

Reset
REQ-031 RESET has priority over all inputs, including START, and acts on the next rising edge of CLK.
REQ-032 Reset values: state IDLE, address 0, LOAD_COUNT 0, IN_READY 0, WE 0, WADDR 0, WDATA 0, CPU_HOLD 1, DONE 0, OVERFLOW 0.
REQ-033 RESET during LOAD or FILL abandons the load; partially written RAM content is undefined and DONE stays low.

Configuration
REQ-034 Macro IMEM_LOADER_CHECKSUM_EN shall add output CHECKSUM (WORD_W bits), the XOR of all accepted program words; fill words are excluded.
- CHECKSUM clears on START and RESET and is stable while DONE=1.
- Without the macro, the CHECKSUM port and its logic are absent and all other behaviour is identical.

Structure
REQ-035 Shared package imem_pkg shall hold the FSM state typedef and the default END_WORD constant.
REQ-036 The block is a single module with no sub-module; the address counter and FSM are inline.

Verification
REQ-037 Three words A, B, C (IN_LAST on C), DEPTH=8 -> RAM[0..2]=A,B,C; RAM[3..7]=FFFFFFFF; DONE 5 cycles after C; LOAD_COUNT=3; OVERFLOW=0.
REQ-038 Eight words with IN_LAST on the 8th, DEPTH=8 -> no FILL cycles; DONE on the next cycle; OVERFLOW=0.
REQ-039 Nine words without IN_LAST, DEPTH=8 -> eight words written; IN_READY low after the 8th; OVERFLOW=1; LOAD_COUNT=8.
REQ-040 IN_VALID toggled randomly with gaps -> WE only on transfer cycles; addresses strictly consecutive.
REQ-041 RESET asserted in the 2nd FILL cycle -> next cycle IDLE, CPU_HOLD=1, DONE=0; a following START reloads correctly.
REQ-042 START asserted during LOAD -> ignored; START in FIN -> new load, DONE cleared; with IMEM_LOADER_CHECKSUM_EN, words 1,2,4 give CHECKSUM=7.
